// File: rtl/execute.sv
// execute: integer execute stage with a single-cycle ALU and an iterative 64-step
// divider (IDLE/BUSY/DONE). Define ITER_MUL_EN to run the multiplies on the same FSM.
package execute_pkg;
    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
        OP_SLT, OP_SLTU, OP_LUI, OP_AUIPC, OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW,
        OP_SRAW, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW, OP_DIV, OP_DIVU,
        OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
    } alu_op_t;

    typedef struct packed {
        alu_op_t     alu_op;
        logic        use_imm;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
    } ctl_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] imm;
        logic [63:0] pc;
        logic [4:0]  dst;
        logic [31:0] instr;
        logic [11:0] csr_waddr;
        logic [63:0] csr_data;
        logic [63:0] excep_wdata;
        logic [1:0]  priv;
    } decode_data_t;

    typedef struct packed {
        logic [63:0] aluout;
        logic [63:0] rd;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [31:0] instr;
        logic [11:0] csr_waddr;
        logic [63:0] csr_data;
        logic [63:0] excep_wdata;
        logic [1:0]  priv_nxt;
    } exec_data_t;
endpackage

module execute
    import execute_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         stall_in,
    input  decode_data_t dataD,
    output exec_data_t   dataE,
    output logic         exec_busy
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t       r_state, w_state_nxt;
    logic [6:0]   r_cnt;
    logic [63:0]  r_hi, r_lo, r_opb, r_result;
    logic         r_neg_q, r_neg_r, r_is_w, r_is_rem, r_is_mul, r_mul_hi;

    alu_op_t      w_op;
    logic [63:0]  w_a, w_b, w_alu, w_ext_a, w_ext_b, w_mag_a, w_mag_b;
    logic [31:0]  w_w32;
    logic         w_sext32, w_is_div, w_is_mul, w_is_long, w_is_rem, w_mul_hi;
    logic         w_sgn_a, w_sgn_b, w_is_w, w_neg_a, w_neg_b;
    logic [64:0]  w_shift, w_sum;
    logic [63:0]  w_hi_nxt, w_lo_nxt, w_res64, w_res;
    logic [127:0] w_p128;

    assign w_op = dataD.ctl.alu_op;
    assign w_a  = dataD.rs1;
    assign w_b  = dataD.ctl.use_imm ? dataD.imm : dataD.rs2;

    always_comb begin
        w_is_div = 1'b0;
        w_is_mul = 1'b0;
        w_is_rem = 1'b0;
        w_mul_hi = 1'b0;
        w_sgn_a  = 1'b0;
        w_sgn_b  = 1'b0;
        w_is_w   = 1'b0;
        case (w_op)
            OP_DIV:    begin w_is_div = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            OP_DIVU:   w_is_div = 1'b1;
            OP_REM:    begin w_is_div = 1'b1; w_is_rem = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            OP_REMU:   begin w_is_div = 1'b1; w_is_rem = 1'b1; end
            OP_DIVW:   begin w_is_div = 1'b1; w_is_w = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            OP_DIVUW:  begin w_is_div = 1'b1; w_is_w = 1'b1; end
            OP_REMW:   begin w_is_div = 1'b1; w_is_w = 1'b1; w_is_rem = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            OP_REMUW:  begin w_is_div = 1'b1; w_is_w = 1'b1; w_is_rem = 1'b1; end
            OP_MUL:    begin w_is_mul = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            OP_MULH:   begin w_is_mul = 1'b1; w_mul_hi = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            OP_MULHSU: begin w_is_mul = 1'b1; w_mul_hi = 1'b1; w_sgn_a = 1'b1; end
            OP_MULHU:  begin w_is_mul = 1'b1; w_mul_hi = 1'b1; end
            OP_MULW:   begin w_is_mul = 1'b1; w_is_w = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            default:   w_is_div = 1'b0;
        endcase
    end

`ifdef ITER_MUL_EN
    assign w_is_long = w_is_div | w_is_mul;
`else
    assign w_is_long = w_is_div;
`endif

    // *W ops are widened to 64 bits first so overflow and zero cases fall out of the 64-bit datapath
    assign w_ext_a = w_is_w ? {{32{w_sgn_a & w_a[31]}}, w_a[31:0]} : w_a;
    assign w_ext_b = w_is_w ? {{32{w_sgn_b & w_b[31]}}, w_b[31:0]} : w_b;
    assign w_neg_a = w_sgn_a & w_ext_a[63];
    assign w_neg_b = w_sgn_b & w_ext_b[63];
    assign w_mag_a = w_neg_a ? -w_ext_a : w_ext_a;
    assign w_mag_b = w_neg_b ? -w_ext_b : w_ext_b;

`ifndef ITER_MUL_EN
    logic [127:0] w_mprod;
    assign w_mprod = {{64{w_neg_a}}, w_ext_a} * {{64{w_neg_b}}, w_ext_b};
`endif

    always_comb begin
        w_alu    = '0;
        w_w32    = '0;
        w_sext32 = 1'b0;
        case (w_op)
            OP_ADD:   w_alu = w_a + w_b;
            OP_SUB:   w_alu = w_a - w_b;
            OP_AND:   w_alu = w_a & w_b;
            OP_OR:    w_alu = w_a | w_b;
            OP_XOR:   w_alu = w_a ^ w_b;
            OP_SLL:   w_alu = w_a << w_b[5:0];
            OP_SRL:   w_alu = w_a >> w_b[5:0];
            OP_SRA:   w_alu = $signed(w_a) >>> w_b[5:0];
            OP_SLT:   w_alu = {63'd0, $signed(w_a) < $signed(w_b)};
            OP_SLTU:  w_alu = {63'd0, w_a < w_b};
            OP_LUI:   w_alu = dataD.imm;
            OP_AUIPC: w_alu = dataD.pc + dataD.imm;
            OP_ADDW:  begin w_w32 = w_a[31:0] + w_b[31:0]; w_sext32 = 1'b1; end
            OP_SUBW:  begin w_w32 = w_a[31:0] - w_b[31:0]; w_sext32 = 1'b1; end
            OP_SLLW:  begin w_w32 = w_a[31:0] << w_b[4:0]; w_sext32 = 1'b1; end
            OP_SRLW:  begin w_w32 = w_a[31:0] >> w_b[4:0]; w_sext32 = 1'b1; end
            OP_SRAW:  begin w_w32 = $signed(w_a[31:0]) >>> w_b[4:0]; w_sext32 = 1'b1; end
`ifndef ITER_MUL_EN
            OP_MUL:   w_alu = w_mprod[63:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_alu = w_mprod[127:64];
            OP_MULW:  begin w_w32 = w_mprod[31:0]; w_sext32 = 1'b1; end
`endif
            default:  w_alu = '0;
        endcase
        if (w_sext32) w_alu = {{32{w_w32[31]}}, w_w32};
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        exec_busy   = 1'b0;
        case (r_state)
            S_IDLE: begin
                exec_busy = w_is_long & ~flush;
                if (w_is_long && !flush) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                exec_busy = ~flush;
                if (flush)                w_state_nxt = S_IDLE;
                else if (r_cnt == 7'd63)  w_state_nxt = S_DONE;
            end
            S_DONE:  if (flush || !stall_in) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One step: restoring divide shifts left into r_hi; shift-add multiply shifts right out of r_lo
    always_comb begin
        w_shift = {r_hi, r_lo[63]};
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : 65'd0);
        if (r_is_mul) begin
            w_hi_nxt = w_sum[64:1];
            w_lo_nxt = {w_sum[0], r_lo[63:1]};
        end else if (w_shift >= {1'b0, r_opb}) begin
            w_hi_nxt = w_shift[63:0] - r_opb;
            w_lo_nxt = {r_lo[62:0], 1'b1};
        end else begin
            w_hi_nxt = w_shift[63:0];
            w_lo_nxt = {r_lo[62:0], 1'b0};
        end
        w_p128 = r_neg_q ? -{w_hi_nxt, w_lo_nxt} : {w_hi_nxt, w_lo_nxt};
        if (r_is_mul)      w_res64 = r_mul_hi ? w_p128[127:64] : w_p128[63:0];
        else if (r_is_rem) w_res64 = r_neg_r ? -w_hi_nxt : w_hi_nxt;
        else               w_res64 = r_neg_q ? -w_lo_nxt : w_lo_nxt;
        w_res = r_is_w ? {{32{w_res64[31]}}, w_res64[31:0]} : w_res64;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_w   <= 1'b0;
            r_is_rem <= 1'b0;
            r_is_mul <= 1'b0;
            r_mul_hi <= 1'b0;
        end else if (r_state == S_IDLE && w_is_long && !flush) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= w_is_mul ? w_mag_b : w_mag_a;
            r_opb    <= w_is_mul ? w_mag_a : w_mag_b;
            // a zero divisor keeps the all-ones quotient unsigned-looking
            r_neg_q  <= (w_neg_a ^ w_neg_b) & (|w_ext_b);
            r_neg_r  <= w_neg_a;
            r_is_w   <= w_is_w;
            r_is_rem <= w_is_rem;
            r_is_mul <= w_is_mul;
            r_mul_hi <= w_mul_hi;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + 7'd1;
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            if (r_cnt == 7'd63) r_result <= w_res;
        end
    end

    always_comb begin
        dataE.aluout      = (r_state == S_DONE) ? r_result : w_alu;
        dataE.rd          = dataD.rs2;
        dataE.ctl         = dataD.ctl;
        dataE.dst         = dataD.dst;
        dataE.instr       = dataD.instr;
        dataE.csr_waddr   = dataD.csr_waddr;
        dataE.csr_data    = dataD.csr_data;
        dataE.excep_wdata = dataD.excep_wdata;
        dataE.priv_nxt    = dataD.priv;
    end
endmodule

// File: tb/tb_execute.sv
// tb_execute: directed bench for execute; expected results are queued when an op
// is driven and popped when the stage presents its result.
module tb_execute;
    import execute_pkg::*;

    logic         clk = 1'b0;
    logic         reset, flush, stall_in;
    decode_data_t dataD;
    exec_data_t   dataE;
    logic         exec_busy;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [63:0] sb_exp[$];
    string       sb_tag[$];

    execute dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .stall_in  (stall_in),
        .dataD     (dataD),
        .dataE     (dataE),
        .exec_busy (exec_busy)
    );

    always #5 clk = ~clk;

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: observed no $finish, required finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input logic [63:0] obs);
        string       tag;
        logic [63:0] exp;
        tag = sb_tag.pop_front();
        exp = sb_exp.pop_front();
        check(tag, obs, exp);
    endtask

    task automatic set_op(input alu_op_t op, input logic [63:0] a, input logic [63:0] b);
        dataD            = '0;
        dataD.ctl.alu_op = op;
        dataD.ctl.reg_wr = 1'b1;
        dataD.rs1        = a;
        dataD.rs2        = b;
        dataD.imm        = b;
        dataD.pc         = a;
        dataD.dst        = 5'd1;
    endtask

    task automatic single(input string tag, input alu_op_t op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp);
        @(posedge clk); #1;
        set_op(op, a, b);
        sb_exp.push_back(exp);
        sb_tag.push_back(tag);
        #1;
        check({tag, "_busy"}, 64'(exec_busy), 64'd0);
        sb_check(dataE.aluout);
    endtask

    // leaves the DUT sampled in DONE with stall_in as the caller set it
    task automatic long_op(input string tag, input alu_op_t op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp);
        int n;
        @(posedge clk); #1;
        set_op(op, a, b);
        sb_exp.push_back(exp);
        sb_tag.push_back(tag);
        #1;
        n = 0;
        while (exec_busy && n < 200) begin
            n++;
            @(posedge clk); #2;
        end
        check({tag, "_latency"}, 64'(n), 64'd65);
        sb_check(dataE.aluout);
    endtask

    initial begin : stim
        int nb;
        reset    = 1'b1;
        flush    = 1'b0;
        stall_in = 1'b0;
        set_op(OP_ADD, 64'd5, 64'd7);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset_busy", 64'(exec_busy), 64'd0);
        check("reset_add", dataE.aluout, 64'd12);

        single("add",    OP_ADD,   64'd5, 64'd7, 64'd12);
        single("sub",    OP_SUB,   64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
        single("slt",    OP_SLT,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
        single("sltu",   OP_SLTU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        single("sra",    OP_SRA,   64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
        single("addw",   OP_ADDW,  64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
        single("srlw",   OP_SRLW,  64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0000_0000_0800_0000);
        single("lui",    OP_LUI,   64'd0, 64'h1234_5000, 64'h1234_5000);
        single("auipc",  OP_AUIPC, 64'h1000, 64'h2000, 64'h3000);
        single("mul",    OP_MUL,   64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        single("mulh",   OP_MULH,  64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        single("mulhu",  OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1);
        single("mulhsu", OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        single("mulw",   OP_MULW,  64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);

        @(posedge clk); #1;
        set_op(OP_XOR, 64'hF0F0, 64'h0FF0);
        dataD.dst       = 5'd17;
        dataD.instr     = 32'hDEAD_BEEF;
        dataD.csr_waddr = 12'h305;
        dataD.priv      = 2'd3;
        #1;
        check("pass_rd", dataE.rd, 64'h0FF0);
        check("pass_fields", 64'({dataE.dst, dataE.instr, dataE.csr_waddr, dataE.priv_nxt}),
              64'({5'd17, 32'hDEAD_BEEF, 12'h305, 2'd3}));
        check("xor", dataE.aluout, 64'hFF00);

        stall_in = 1'b1;
        single("stall_add", OP_ADD, 64'd100, 64'd23, 64'd123);
        stall_in = 1'b0;

        long_op("div_neg", OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        stall_in = 1'b1;
        repeat (3) begin @(posedge clk); #2; end
        check("done_stall_hold", dataE.aluout, 64'hFFFF_FFFF_FFFF_FFFD);
        check("done_stall_busy", 64'(exec_busy), 64'd0);
        stall_in = 1'b0;

        long_op("rem_neg",   OP_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        long_op("divu_zero", OP_DIVU,  64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        long_op("remu_zero", OP_REMU,  64'h1234, 64'd0, 64'h1234);
        long_op("div_zero",  OP_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        long_op("rem_zero",  OP_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9);
        long_op("div_ovf",   OP_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
        long_op("rem_ovf",   OP_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        long_op("divw_one",  OP_DIVW,  64'hFFFF_FFFF_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000);
        long_op("divw_ovf",  OP_DIVW,  64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
        long_op("divuw",     OP_DIVUW, 64'h1_0000_0010, 64'd3, 64'd5);
        long_op("remw",      OP_REMW,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        long_op("divu_big",  OP_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'h1999_9999_9999_9999);

        // flush on BUSY cycle 10
        @(posedge clk); #1;
        set_op(OP_DIV, 64'd100, 64'd3);
        repeat (10) begin @(posedge clk); #2; end
        flush = 1'b1;
        #1;
        check("flush_busy_low", 64'(exec_busy), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        set_op(OP_ADD, 64'd5, 64'd7);
        sb_exp.push_back(64'd12);
        sb_tag.push_back("flush_then_add");
        #1;
        check("flush_idle_busy", 64'(exec_busy), 64'd0);
        sb_check(dataE.aluout);
        nb = 0;
        repeat (70) begin @(posedge clk); #2; if (exec_busy || dataE.aluout !== 64'd12) nb++; end
        check("flush_no_result", 64'(nb), 64'd0);

        // flush together with the issue keeps IDLE
        @(posedge clk); #1;
        set_op(OP_DIV, 64'd100, 64'd3);
        flush = 1'b1;
        #1;
        check("flush_issue_busy", 64'(exec_busy), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        set_op(OP_ADD, 64'd1, 64'd2);
        #1;
        check("flush_issue_idle", 64'(exec_busy), 64'd0);
        check("flush_issue_add", dataE.aluout, 64'd3);

        // reset while BUSY abandons the divide
        @(posedge clk); #1;
        set_op(OP_DIVU, 64'd1000, 64'd7);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        set_op(OP_OR, 64'h0F, 64'hF0);
        nb = 0;
        repeat (70) begin #1; if (exec_busy || dataE.aluout !== 64'hFF) nb++; @(posedge clk); #1; end
        check("reset_busy_abandon", 64'(nb), 64'd0);

        check("sb_drained", 64'(sb_exp.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock, rising edge.
REQ-002 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port flush  input  1  squash of the in-flight instruction.
REQ-004 SHALL have port stall_in  input  1  downstream (memory) stall; high while memory is in WAITING.
REQ-005 SHALL have port dataD  input  decode_data_t  decoded instruction: ctl, operands, dst, instr, csr fields, priv.
REQ-006 SHALL have port dataE  output  exec_data_t  result bundle to memory: aluout, rd (store data), ctl, dst, instr, csr_waddr, csr_data, excep_wdata, priv_nxt.
REQ-007 SHALL have port exec_busy  output  1  stall request to fetch and decode while a multi-cycle op is pending.
REQ-008 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-009 SHALL compute single-cycle ops combinationally: add/sub, logic, shifts, slt/sltu, lui/auipc and the *W variants (low 32 bits, sign-extended to 64); dataE.aluout valid in the same cycle; exec_busy low.
REQ-010 SHALL pass ctl, dst, instr and the csr/exception/priv fields from dataD to dataE unchanged; rd = rs2 value.
REQ-011 SHALL run DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW and REMUW on an iterative restoring divider with FSM states IDLE, BUSY and DONE.
REQ-012 IDLE: a divide op on dataD SHALL assert exec_busy combinationally, latch operands and sign flags, load a 7-bit counter to 0 and go to BUSY.
REQ-013 BUSY: one quotient bit per cycle; the state SHALL go to DONE when the counter reaches 63 (64 iterations); exec_busy high throughout.
REQ-014 DONE: aluout SHALL equal the latched result and exec_busy SHALL be low; DONE SHALL hold while stall_in=1 and SHALL return to IDLE when stall_in=0 or flush=1.
REQ-015 Total latency SHALL be fixed: exec_busy high for exactly 65 cycles (issue cycle plus 64 BUSY cycles), then the result appears in DONE.
REQ-016 Signed ops SHALL divide magnitudes and fix signs: quotient sign = XOR of operand signs; remainder takes the dividend sign.
REQ-017 Division by zero SHALL give quotient all-ones and remainder = dividend, at the same fixed latency.
REQ-018 Signed overflow (most-negative / -1) SHALL give quotient = dividend and remainder 0, at the same fixed latency.
REQ-019 *W ops SHALL use operand bits [31:0] and sign-extend bit 31 of the 32-bit result; 32-bit zero/overflow rules apply to the 32-bit values.
REQ-020 flush in BUSY or DONE SHALL force IDLE on the next edge and deassert exec_busy in that cycle; no result is delivered.
REQ-021 flush in the same cycle as a divide issue SHALL keep the FSM in IDLE.
REQ-022 While stall_in=1, single-cycle outputs SHALL stay combinational from dataD, which the pipeline holds stable.

Reset
REQ-023 reset SHALL force IDLE and clear the counter, the operand/result registers and the latched signs; exec_busy SHALL read 0 when no divide op is present.
REQ-024 reset during BUSY SHALL abandon the operation; nothing is delivered afterwards.

Configuration
REQ-025 Macro ITER_MUL_EN defined: MUL, MULH, MULHSU, MULHU and MULW SHALL use the same FSM with a 64-iteration shift-add multiplier (65-cycle exec_busy, DONE rules as for divide).
REQ-026 Macro ITER_MUL_EN undefined: the multiply ops SHALL be single-cycle combinational with exec_busy low; divide behaviour is unchanged.

Verification
REQ-027 ADD, rs1=5, rs2=7 -> aluout=12 in the same cycle; exec_busy=0.
REQ-028 DIV, rs1=-7, rs2=2 -> exec_busy high 65 cycles, then aluout=-3; REM with the same operands -> -1.
REQ-029 DIVU, rs2=0, rs1=0x1234 -> quotient 0xFFFF_FFFF_FFFF_FFFF; REMU -> 0x1234.
REQ-030 DIV, rs1=0x8000_0000_0000_0000, rs2=-1 -> aluout=0x8000_0000_0000_0000; REM -> 0.
REQ-031 DIVW, rs1=0xFFFF_FFFF_8000_0000, rs2=1 -> aluout=0xFFFF_FFFF_8000_0000.
REQ-032 Issue DIV, flush on BUSY cycle 10 -> IDLE next cycle, exec_busy=0; a following ADD completes in a single cycle.
